// File: rtl/firtrig_pkg.sv
// -----------------------------------------------------------------------------
// firtrig_pkg
// Shared definitions for the waveform record-capture path: default widths,
// the FIFO entry layout and the capture state encoding.
// -----------------------------------------------------------------------------
package firtrig_pkg;

   localparam int BITS   = 56;   // one data word: 4 samples x 14 bits
   localparam int ADDR_W = 8;    // FIFO address width, 256 entries
   localparam int TS_W   = 48;   // timestamp width; TS_W + ADDR_W == BITS

   // One FIFO slot: header/last markers travel with the word.
   typedef struct packed {
      logic            hdr;
      logic            last;
      logic [BITS-1:0] data;
   } fifo_entry_t;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      CAPTURE = 1'b1
   } cap_state_t;

endpackage

// File: rtl/wfm_capture_if.sv
// -----------------------------------------------------------------------------
// wfm_capture_if
// Valid/ready readout stream carrying FIFO head words.
//   out_data  : head word
//   out_hdr   : head word is a record header
//   out_last  : head word closes its record
//   out_valid : a head word is present
//   out_ready : consumer accepts the head word
// master = producer (wfm_capture), slave = readout logic.
// -----------------------------------------------------------------------------
interface wfm_capture_if
   import firtrig_pkg::*;
#(
   parameter int BITS = firtrig_pkg::BITS
) ();

   logic [BITS-1:0] out_data;
   logic            out_hdr;
   logic            out_last;
   logic            out_valid;
   logic            out_ready;

   modport master (
      output out_data, out_hdr, out_last, out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data, out_hdr, out_last, out_valid,
      output out_ready
   );

endinterface

// File: rtl/wfm_fifo.sv
// -----------------------------------------------------------------------------
// wfm_fifo
// Synchronous first-word-fall-through FIFO, async active-low reset.
//   clk, reset_n : clock and reset
//   push, wdata  : write request and word
//   pop          : consume the head word (ignored when empty)
//   rdata        : head word, reads 0 while empty
//   valid        : FIFO not empty (registered)
//   full         : FIFO full (registered)
//   count, free  : registered occupancy and free slots
// -----------------------------------------------------------------------------
module wfm_fifo #(
   parameter int WIDTH  = 58,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              pop,
   output logic [WIDTH-1:0]  rdata,
   output logic              valid,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic [ADDR_W:0]   free
);

   localparam int              DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   logic [WIDTH-1:0]  mem_r [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_r;
   logic [ADDR_W-1:0] rd_ptr_r;
   logic [ADDR_W:0]   count_r;
   logic [ADDR_W:0]   free_r;
   logic [ADDR_W:0]   count_s;
   logic              valid_r;
   logic              full_r;
   logic              do_push_s;
   logic              do_pop_s;

   // Qualify requests and work out the next occupancy (push+pop cancels).
   always_comb begin
      do_push_s = push & ~full_r;
      do_pop_s  = pop & valid_r;
      case ({do_push_s, do_pop_s})
         2'b10:   count_s = count_r + (ADDR_W+1)'(1);
         2'b01:   count_s = count_r - (ADDR_W+1)'(1);
         default: count_s = count_r;
      endcase
   end

   // Storage array; contents are meaningless until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointers, occupancy and status flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= {ADDR_W{1'b0}};
         rd_ptr_r <= {ADDR_W{1'b0}};
         count_r  <= {(ADDR_W+1){1'b0}};
         free_r   <= DEPTH_C;
         valid_r  <= 1'b0;
         full_r   <= 1'b0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
         end
         count_r <= count_s;
         free_r  <= DEPTH_C - count_s;
         valid_r <= (count_s != {(ADDR_W+1){1'b0}});
         full_r  <= (count_s == DEPTH_C);
      end
   end

   // Head word falls through; forced to zero while empty so stale RAM never shows.
   assign rdata = valid_r ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
   assign valid = valid_r;
   assign full  = full_r;
   assign count = count_r;
   assign free  = free_r;

endmodule

// File: rtl/wfm_fifo_chk.sv
// -----------------------------------------------------------------------------
// wfm_fifo_chk
// Property checker for the capture FIFO.
//   clk, reset_n : clock and async active-low reset
//   push         : write request into the FIFO
//   full         : FIFO full flag
//   count        : FIFO occupancy
// -----------------------------------------------------------------------------
module wfm_fifo_chk #(
   parameter int ADDR_W = 8
) (
   input logic            clk,
   input logic            reset_n,
   input logic            push,
   input logic            full,
   input logic [ADDR_W:0] count
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(1 << ADDR_W);

   // Admission control guarantees room for the whole record, so a write
   // while full means the free-count logic is broken.
   a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(push && full));

   a_count_range: assert property (@(posedge clk) disable iff (!reset_n)
      count <= DEPTH_C);

endmodule

// File: rtl/wfm_capture.sv
// -----------------------------------------------------------------------------
// wfm_capture
// Record capture behind the waveform delay line. An accepted trigger writes a
// header {timestamp, length} followed by a fixed window of delayed data words
// into an FWFT FIFO that drains over a valid/ready stream.
//   clk, reset_n : clock, async active-low reset
//   d_in         : delayed waveform word, valid every cycle
//   trig         : trigger request
//   len          : record length in data words (0 is treated as 1)
//   stream       : readout stream (master side)
//   busy         : capture in progress
//   drop_cnt     : saturating count of refused triggers
// -----------------------------------------------------------------------------
module wfm_capture
   import firtrig_pkg::*;
#(
   parameter int BITS   = firtrig_pkg::BITS,
   parameter int ADDR_W = firtrig_pkg::ADDR_W,
   parameter int TS_W   = firtrig_pkg::TS_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [BITS-1:0]   d_in,
   input  logic              trig,
   input  logic [ADDR_W-1:0] len,
   wfm_capture_if.master     stream,
   output logic              busy,
   output logic [15:0]       drop_cnt
);

   cap_state_t        state_r;
   cap_state_t        state_s;
   logic [ADDR_W-1:0] cnt_r;
   logic [ADDR_W-1:0] cnt_s;
   logic [TS_W-1:0]   ts_r;
   logic [15:0]       drop_r;
   logic              busy_r;

   logic [ADDR_W-1:0] eff_len_s;
   logic [ADDR_W:0]   need_s;
   logic              push_s;
   logic              drop_inc_s;
   fifo_entry_t       wentry_s;
   fifo_entry_t       rentry_s;
   logic              fifo_valid_s;
   logic              fifo_full_s;
   logic [ADDR_W:0]   fifo_count_s;
   logic [ADDR_W:0]   fifo_free_s;
   logic              pop_s;

   // Effective length and room needed (header + data words).
   always_comb begin
      if (len == {ADDR_W{1'b0}}) begin
         eff_len_s = ADDR_W'(1);
      end else begin
         eff_len_s = len;
      end
      need_s = {1'b0, eff_len_s} + (ADDR_W+1)'(1);
   end

   // Capture FSM next state and FIFO write generation.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      push_s     = 1'b0;
      drop_inc_s = 1'b0;
      wentry_s   = {1'b0, 1'b0, {BITS{1'b0}}};
      case (state_r)
         IDLE: begin
            if (trig) begin
               // Registered free count only: a pop this cycle earns no credit.
               if (fifo_free_s >= need_s) begin
                  push_s        = 1'b1;
                  wentry_s.hdr  = 1'b1;
                  wentry_s.last = 1'b0;
                  wentry_s.data = {ts_r, eff_len_s};
                  cnt_s         = eff_len_s;
                  state_s       = CAPTURE;
               end else begin
                  drop_inc_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         CAPTURE: begin
            push_s        = 1'b1;
            wentry_s.hdr  = 1'b0;
            wentry_s.last = (cnt_r == ADDR_W'(1));
            wentry_s.data = d_in;
            cnt_s         = cnt_r - ADDR_W'(1);
            if (cnt_r == ADDR_W'(1)) begin
               state_s = IDLE;
            end else begin
               state_s = CAPTURE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, word counter, timestamp, busy flag and drop counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         cnt_r   <= {ADDR_W{1'b0}};
         ts_r    <= {TS_W{1'b0}};
         busy_r  <= 1'b0;
         drop_r  <= 16'h0000;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         ts_r    <= ts_r + TS_W'(1);
         busy_r  <= (state_s == CAPTURE);
         if (drop_inc_s && (drop_r != 16'hFFFF)) begin
            drop_r <= drop_r + 16'd1;
         end
      end
   end

   assign pop_s = fifo_valid_s & stream.out_ready;

   wfm_fifo #(
      .WIDTH  ($bits(fifo_entry_t)),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_s),
      .wdata   (wentry_s),
      .pop     (pop_s),
      .rdata   (rentry_s),
      .valid   (fifo_valid_s),
      .full    (fifo_full_s),
      .count   (fifo_count_s),
      .free    (fifo_free_s)
   );

   wfm_fifo_chk #(
      .ADDR_W (ADDR_W)
   ) u_chk (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_s),
      .full    (fifo_full_s),
      .count   (fifo_count_s)
   );

   assign stream.out_data  = rentry_s.data;
   assign stream.out_hdr   = rentry_s.hdr;
   assign stream.out_last  = rentry_s.last;
   assign stream.out_valid = fifo_valid_s;
   assign busy             = busy_r;
   assign drop_cnt         = drop_r;

endmodule

// File: tb/tb_wfm_capture.sv
module tb_wfm_capture;
   import firtrig_pkg::*;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [BITS-1:0]   d_in;
   logic              trig;
   logic [ADDR_W-1:0] len;
   logic              busy;
   logic [15:0]       drop_cnt;

   int          n_pass  = 0;
   int          n_total = 0;
   int          cyc     = 0;
   int          c0;
   fifo_entry_t exp_q[$];
   fifo_entry_t e_m;

   wfm_capture_if sif ();

   wfm_capture dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .d_in     (d_in),
      .trig     (trig),
      .len      (len),
      .stream   (sif.master),
      .busy     (busy),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   // Data word presented during cycle c.
   function automatic logic [BITS-1:0] mk(input int c);
      logic [47:0] v;
      v = 48'(c);
      return {8'hA5, v};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   // Advance one cycle; inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      d_in = mk(cyc);
   endtask

   // Queue the words an accepted trigger in cycle t with length l must produce.
   task automatic expect_record(input int t, input int l);
      fifo_entry_t e;
      e.hdr  = 1'b1;
      e.last = 1'b0;
      e.data = {48'(t), 8'(l)};
      exp_q.push_back(e);
      for (int k = 1; k <= l; k++) begin
         e.hdr  = 1'b0;
         e.last = (k == l);
         e.data = mk(t + k);
         exp_q.push_back(e);
      end
   endtask

   // Scoreboard: every accepted stream word must match the next expected word.
   always @(negedge clk) begin
      if (reset_n && sif.out_valid && sif.out_ready) begin
         check("stream_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e_m = exp_q.pop_front();
            check("stream_word", {6'b0, sif.out_hdr, sif.out_last, sif.out_data},
                  {6'b0, e_m.hdr, e_m.last, e_m.data});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n       = 1'b0;
      d_in          = mk(0);
      trig          = 1'b0;
      len           = 8'd0;
      sif.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 64'(sif.out_valid), 64'd0);
      check("rst_busy",  64'(busy),          64'd0);
      check("rst_drop",  64'(drop_cnt),      64'd0);
      check("rst_data",  64'(sif.out_data),  64'd0);
      check("rst_hdr",   64'(sif.out_hdr),   64'd0);
      check("rst_last",  64'(sif.out_last),  64'd0);
      reset_n = 1'b1;
      cyc     = 0;
      d_in    = mk(0);

      // Reset asserted in the middle of a record.
      tick();
      len  = 8'd4;
      trig = 1'b1;
      tick();
      trig = 1'b0;
      check("mid_busy", 64'(busy), 64'd1);
      tick();
      check("mid_valid", 64'(sif.out_valid), 64'd1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_busy",  64'(busy),          64'd0);
      check("mid_rst_valid", 64'(sif.out_valid), 64'd0);
      check("mid_rst_drop",  64'(drop_cnt),      64'd0);
      check("mid_rst_data",  64'(sif.out_data),  64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc     = 0;
      d_in    = mk(0);
      check("rel_valid", 64'(sif.out_valid), 64'd0);
      check("rel_drop",  64'(drop_cnt),      64'd0);
      tick();
      check("rel_no_partial", 64'(sif.out_valid), 64'd0);

      // Basic record: len=3, trigger in cycle 10.
      sif.out_ready = 1'b1;
      while (cyc < 10) tick();
      len  = 8'd3;
      trig = 1'b1;
      expect_record(10, 3);
      tick();
      trig = 1'b0;
      check("basic_valid_rise", 64'(sif.out_valid), 64'd1);
      check("basic_hdr",        64'(sif.out_hdr),   64'd1);
      check("basic_hdr_word",   64'(sif.out_data),  64'({48'd10, 8'd3}));
      check("basic_busy",       64'(busy),          64'd1);
      tick();
      check("basic_d0",   64'(sif.out_data), 64'(mk(11)));
      check("basic_last0", 64'(sif.out_last), 64'd0);
      tick();
      check("basic_busy_end", 64'(busy), 64'd1);
      tick();
      check("basic_idle",  64'(busy),         64'd0);
      check("basic_last",  64'(sif.out_last), 64'd1);
      check("basic_d2",    64'(sif.out_data), 64'(mk(13)));
      tick();
      check("basic_drained", 64'(sif.out_valid), 64'd0);

      // len=0 is clamped to a one-word record (trigger in cycle 15).
      len  = 8'd0;
      trig = 1'b1;
      expect_record(15, 1);
      tick();
      trig = 1'b0;
      check("clamp_hdr_word", 64'(sif.out_data), 64'({48'd15, 8'd1}));
      tick();
      check("clamp_last", 64'(sif.out_last), 64'd1);
      check("clamp_busy", 64'(busy),         64'd0);
      tick();
      check("clamp_drained", 64'(sif.out_valid), 64'd0);

      // Back-to-back: len=2 with trigger held from cycle 18.
      len  = 8'd2;
      trig = 1'b1;
      expect_record(18, 2);
      expect_record(21, 2);
      expect_record(24, 2);
      for (int i = 1; i <= 9; i++) begin
         tick();
         if (i == 1) check("b2b_busy1", 64'(busy), 64'd1);
         if (i == 3) check("b2b_gap",   64'(busy), 64'd0);
         if (i == 4) check("b2b_busy2", 64'(busy), 64'd1);
      end
      trig = 1'b0;
      check("b2b_drop", 64'(drop_cnt), 64'd0);
      tick();
      check("b2b_drained", 64'(sif.out_valid), 64'd0);

      // Backpressure and refusal (cycle 28 onward).
      sif.out_ready = 1'b0;
      len  = 8'd200;
      trig = 1'b1;
      expect_record(28, 200);
      tick();
      trig = 1'b0;
      repeat (200) tick();
      check("bp_idle",       64'(busy),     64'd0);
      check("bp_drop_before", 64'(drop_cnt), 64'd0);
      trig = 1'b1;
      tick();
      check("bp_refused", 64'(drop_cnt), 64'd1);
      check("bp_no_busy", 64'(busy),     64'd0);
      len = 8'd54;
      expect_record(230, 54);
      tick();
      trig = 1'b0;
      check("bp_exact_fit_busy", 64'(busy),     64'd1);
      check("bp_exact_fit_drop", 64'(drop_cnt), 64'd1);
      repeat (54) tick();
      check("bp_full_idle", 64'(busy), 64'd0);
      len  = 8'd0;
      trig = 1'b1;
      tick();
      trig = 1'b0;
      check("bp_full_refused", 64'(drop_cnt), 64'd2);
      sif.out_ready = 1'b1;
      for (int i = 0; i < 400 && sif.out_valid; i++) tick();
      check("bp_drain_valid", 64'(sif.out_valid), 64'd0);
      check("bp_drain_all",   64'(exp_q.size()),  64'd0);

      // Near full: 256-word record, pop and push together at count 255.
      sif.out_ready = 1'b0;
      c0   = cyc;
      len  = 8'd255;
      trig = 1'b1;
      expect_record(c0, 255);
      tick();
      trig = 1'b0;
      repeat (254) tick();
      check("nf_last_write_busy", 64'(busy), 64'd1);
      sif.out_ready = 1'b1;
      tick();
      check("nf_idle", 64'(busy), 64'd0);
      len  = 8'd0;
      trig = 1'b1;
      tick();
      trig = 1'b0;
      check("nf_count_held", 64'(drop_cnt), 64'd3);
      for (int i = 0; i < 400 && sif.out_valid; i++) tick();
      check("nf_drain_valid", 64'(sif.out_valid), 64'd0);
      check("nf_drain_all",   64'(exp_q.size()),  64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
